hazard_scoreboard: RTL and testbench

Parametrised per-register scoreboard that replaces fixed single-stage load-use and writeback-port hazard checks in the decode stage. It tracks every in-flight destination register with a latency countdown, a memory-wait flag and an ownership tag. It produces the decode stall from that state. It supports variable-latency units, unknown-latency loads, no-forwarding mode and write-after-write ordering. It sits beside the decoder and observes issue, memory response and writeback.

---
 rtl/hazard_scoreboard_pkg.sv | 32 +++
 rtl/hazard_scoreboard_sb_entry.sv | 59 +++++
 rtl/hazard_scoreboard.sv | 92 +++++++++
 tb/tb_hazard_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared scoreboard definitions: default widths and the per-register entry-state
// encoding. The forwarding unit imports the same encoding.
package hazard_scoreboard_pkg;

    localparam int REG_NUM_DEF        = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;
    localparam int LAT_WIDTH_DEF      = 3;
    localparam int TAG_WIDTH_DEF      = 4;

    typedef enum logic [1:0] {
        ENT_IDLE    = 2'd0,
        ENT_COUNT   = 2'd1,
        ENT_MEMWAIT = 2'd2,
        ENT_READY   = 2'd3
    } entry_state_e;

    // A load entry always has cnt=0, so MEMWAIT and COUNT never overlap.
    function automatic entry_state_e entry_state(input logic busy, input logic cnt_nz,
                                                 input logic mem_wait);
        entry_state_e st;
        if (!busy)
            st = ENT_IDLE;
        else if (mem_wait)
            st = ENT_MEMWAIT;
        else if (cnt_nz)
            st = ENT_COUNT;
        else
            st = ENT_READY;
        return st;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One architectural register's scoreboard entry: busy, latency countdown,
// memory-wait flag and owner tag, with the per-cycle update priority.
module sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int LAT_WIDTH = LAT_WIDTH_DEF,
    parameter int TAG_WIDTH = TAG_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic                 set_load,
    input  logic [LAT_WIDTH-1:0] set_lat,
    input  logic [TAG_WIDTH-1:0] set_tag,
    input  logic                 mem_resp_valid,
    input  logic [TAG_WIDTH-1:0] mem_resp_tag,
    input  logic                 wb_valid,
    input  logic [TAG_WIDTH-1:0] wb_tag,
    output entry_state_e         state
);

    logic                 busy;
    logic                 mem_wait;
    logic [LAT_WIDTH-1:0] cnt;
    logic [TAG_WIDTH-1:0] tag;

    logic wb_hit;
    logic mem_hit;

    // Tag matching lets a stale writeback or response from an overwritten owner fall through.
    assign wb_hit  = busy && wb_valid && (wb_tag == tag);
    assign mem_hit = busy && mem_wait && mem_resp_valid && (mem_resp_tag == tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            mem_wait <= 1'b0;
            cnt      <= '0;
            tag      <= '0;
        end else if (set_en) begin
            busy     <= 1'b1;
            tag      <= set_tag;
            mem_wait <= set_load;
            cnt      <= set_load ? '0 : set_lat;
        end else if (wb_hit) begin
            busy     <= 1'b0;
            mem_wait <= 1'b0;
            cnt      <= '0;
        end else begin
            if (mem_hit)
                mem_wait <= 1'b0;
            if (busy && (cnt != '0))
                cnt <= cnt - 1'b1;
        end
    end

    assign state = entry_state(busy, cnt != '0, mem_wait);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register entries, issue tag counter and
// the source-hazard stall generation.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_NUM        = REG_NUM_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int LAT_WIDTH      = LAT_WIDTH_DEF,
    parameter int TAG_WIDTH      = TAG_WIDTH_DEF,
    parameter int FWD_EN         = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_id,
    input  logic                      rs1_used,
    input  logic                      rs2_used,
    input  logic                      issue_valid,
    input  logic                      issue_wen,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [LAT_WIDTH-1:0]      issue_lat,
    input  logic                      issue_is_load,
    input  logic                      flush,
    input  logic                      mem_resp_valid,
    input  logic [TAG_WIDTH-1:0]      mem_resp_tag,
    input  logic                      wb_valid,
    input  logic [TAG_WIDTH-1:0]      wb_tag,
    output logic                      stall,
    output logic                      stall_mem,
    output logic                      issue_fire,
    output logic [TAG_WIDTH-1:0]      issue_tag
);

    // Handshake: issue_valid is the request, ~stall is the ready; the instruction
    // leaves ID (issue_fire) only in a cycle where both hold and flush is low.

    logic [TAG_WIDTH-1:0] tag_ctr;
    entry_state_e         ent_state [REG_NUM];
    entry_state_e         st1;
    entry_state_e         st2;
    logic                 haz1;
    logic                 haz2;
    logic                 set_any;

    function automatic logic src_hazard(input logic used, input logic [REG_ADDR_WIDTH-1:0] id,
                                        input entry_state_e st);
        return used && (id != '0) &&
               ((st == ENT_COUNT) || (st == ENT_MEMWAIT) || ((FWD_EN == 0) && (st == ENT_READY)));
    endfunction

    assign set_any      = issue_fire && issue_wen && (issue_rd != '0);
    assign ent_state[0] = ENT_IDLE;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_entry
        sb_entry #(
            .LAT_WIDTH(LAT_WIDTH),
            .TAG_WIDTH(TAG_WIDTH)
        ) u_entry (
            .clk           (clk),
            .rst           (rst),
            .set_en        (set_any && (issue_rd == REG_ADDR_WIDTH'(r))),
            .set_load      (issue_is_load),
            .set_lat       (issue_lat),
            .set_tag       (tag_ctr),
            .mem_resp_valid(mem_resp_valid),
            .mem_resp_tag  (mem_resp_tag),
            .wb_valid      (wb_valid),
            .wb_tag        (wb_tag),
            .state         (ent_state[r])
        );
    end

    always_comb begin
        st1       = ent_state[rs1_id];
        st2       = ent_state[rs2_id];
        haz1      = src_hazard(rs1_used, rs1_id, st1);
        haz2      = src_hazard(rs2_used, rs2_id, st2);
        stall     = ~flush & (haz1 | haz2);
        stall_mem = ~flush & ((haz1 & (st1 == ENT_MEMWAIT)) | (haz2 & (st2 == ENT_MEMWAIT)));
    end

    assign issue_fire = issue_valid & ~stall & ~flush;
    assign issue_tag  = tag_ctr;

    always_ff @(posedge clk) begin
        if (rst)
            tag_ctr <= '0;
        else if (issue_fire)
            tag_ctr <= tag_ctr + 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one forwarding instance and one
// no-forwarding instance on shared stimulus.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_id, rs2_id;
    logic       rs1_used, rs2_used;
    logic       issue_valid, issue_wen;
    logic [4:0] issue_rd;
    logic [2:0] issue_lat;
    logic       issue_is_load;
    logic       flush;
    logic       mem_resp_valid;
    logic [3:0] mem_resp_tag;
    logic       wb_valid;
    logic [3:0] wb_tag;

    logic       stall, stall_mem, issue_fire;
    logic [3:0] issue_tag;
    logic       nf_stall, nf_stall_mem, nf_issue_fire;
    logic [3:0] nf_issue_tag;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    hazard_scoreboard #(.FWD_EN(1)) u_dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
        .issue_lat(issue_lat), .issue_is_load(issue_is_load), .flush(flush),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .stall(stall), .stall_mem(stall_mem), .issue_fire(issue_fire), .issue_tag(issue_tag)
    );

    hazard_scoreboard #(.FWD_EN(0)) u_nofwd (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
        .issue_lat(issue_lat), .issue_is_load(issue_is_load), .flush(flush),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .stall(nf_stall), .stall_mem(nf_stall_mem), .issue_fire(nf_issue_fire),
        .issue_tag(nf_issue_tag)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_id = '0; rs2_id = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0; issue_lat = '0;
        issue_is_load = 1'b0; flush = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_tag = '0; wb_valid = 1'b0; wb_tag = '0;
    endtask

    task automatic drive_write(input logic [4:0] rd, input logic [2:0] lat, input logic load);
        idle_inputs();
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = rd;
        issue_lat = lat; issue_is_load = load;
    endtask

    task automatic drive_read(input logic [4:0] rs, input logic on_rs2);
        idle_inputs();
        issue_valid = 1'b1;
        if (on_rs2) begin
            rs2_id = rs; rs2_used = 1'b1;
        end else begin
            rs1_id = rs; rs1_used = 1'b1;
        end
    endtask

    // Scoreboard
    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic chk_fire(input string name);
        logic [3:0] e;
        chk({name, "_fire"}, issue_fire, 1);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_tag observed=%0h expected=<queue empty>", name, issue_tag);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_tag"}, issue_tag, e);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};

        // Reset state: no stall, tag 0, fire follows issue_valid
        issue_valid = 1'b1;
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_stall_mem", stall_mem, 0);
        chk("rst_fire", issue_fire, 1);
        chk("rst_tag", issue_tag, 0);
        rst = 1'b0;

        // ALU x5 lat 0, dependent next cycle: no stall
        drive_write(5'd5, 3'd0, 1'b0); #1;
        chk_fire("alu_x5");
        tick();
        drive_read(5'd5, 1'b0); #1;
        chk("x5_dep_stall", stall, 0);
        chk_fire("x5_dep");
        tick();

        // x7 lat 3: exactly three stall cycles
        drive_write(5'd7, 3'd3, 1'b0); #1;
        chk_fire("alu_x7");
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_read(5'd7, 1'b0); #1;
            chk("x7_dep_stall", stall, 1);
            chk("x7_dep_nofire", issue_fire, 0);
            tick();
        end
        drive_read(5'd7, 1'b0); #1;
        chk("x7_dep_release", stall, 0);
        chk_fire("x7_dep");
        tick();

        // Load x9, response after 5 cycles
        drive_write(5'd9, 3'd0, 1'b1); #1;
        chk_fire("load_x9");
        tick();
        for (int i = 1; i <= 5; i++) begin
            drive_read(5'd9, 1'b1);
            if (i == 5) begin
                mem_resp_valid = 1'b1; mem_resp_tag = 4'd4;
            end
            #1;
            chk("x9_stall", stall, 1);
            chk("x9_stall_mem", stall_mem, 1);
            tick();
        end
        drive_read(5'd9, 1'b1); #1;
        chk("x9_release", stall, 0);
        chk("x9_release_mem", stall_mem, 0);
        chk_fire("x9_dep");
        tick();

        // x0 is never tracked
        drive_write(5'd0, 3'd7, 1'b0); #1;
        chk_fire("wr_x0");
        tick();
        drive_read(5'd0, 1'b0); #1;
        chk("x0_stall", stall, 0);
        chk_fire("x0_dep");
        tick();

        // WAW on x4: load tag 8, then ALU tag 9 lat 7
        drive_write(5'd4, 3'd0, 1'b1); #1;
        chk_fire("waw_load");
        tick();
        drive_write(5'd4, 3'd7, 1'b0); #1;
        chk_fire("waw_alu");
        tick();
        drive_read(5'd4, 1'b0);
        wb_valid = 1'b1; wb_tag = 4'd8; #1;
        chk("waw_old_wb_stall", stall, 1);
        chk("waw_old_wb_mem", stall_mem, 0);
        tick();
        drive_read(5'd4, 1'b0);
        mem_resp_valid = 1'b1; mem_resp_tag = 4'd8; #1;
        chk("waw_stale_resp_stall", stall, 1);
        chk("waw_stale_resp_mem", stall_mem, 0);
        tick();
        drive_read(5'd4, 1'b0);
        wb_valid = 1'b1; wb_tag = 4'd9; #1;
        chk("waw_new_wb_stall", stall, 1);
        tick();
        drive_read(5'd4, 1'b0); #1;
        chk("waw_cleared", stall, 0);
        chk_fire("waw_dep");
        tick();

        // No-forwarding instance
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_write(5'd3, 3'd0, 1'b0); #1;
        chk("nf_wr_fire", nf_issue_fire, 1);
        chk("nf_wr_tag", nf_issue_tag, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_read(5'd3, 1'b0);
            if (i == 2) begin
                wb_valid = 1'b1; wb_tag = 4'd0;
            end
            #1;
            chk("nf_dep_stall", nf_stall, 1);
            chk("nf_dep_nofire", nf_issue_fire, 0);
            tick();
        end
        drive_read(5'd3, 1'b0); #1;
        chk("nf_dep_release", nf_stall, 0);
        chk("nf_dep_fire", nf_issue_fire, 1);
        chk("nf_dep_tag", nf_issue_tag, 1);
        tick();
        drive_write(5'd3, 3'd0, 1'b0); #1;
        chk("nf_wr2_tag", nf_issue_tag, 2);
        tick();
        drive_write(5'd3, 3'd0, 1'b0);
        wb_valid = 1'b1; wb_tag = 4'd2; #1;
        chk("nf_wr3_fire", nf_issue_fire, 1);
        chk("nf_wr3_tag", nf_issue_tag, 3);
        tick();
        drive_read(5'd3, 1'b0);
        wb_valid = 1'b1; wb_tag = 4'd3; #1;
        chk("nf_same_cycle_busy", nf_stall, 1);
        tick();
        drive_read(5'd3, 1'b0); #1;
        chk("nf_final_release", nf_stall, 0);
        chk("nf_final_tag", nf_issue_tag, 4);
        tick();

        // Flush during a hazard stall
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_write(5'd7, 3'd2, 1'b0); #1;
        chk("fl_wr_tag", issue_tag, 0);
        tick();
        drive_read(5'd7, 1'b0);
        flush = 1'b1; #1;
        chk("fl_stall", stall, 0);
        chk("fl_fire", issue_fire, 0);
        chk("fl_tag", issue_tag, 1);
        tick();
        drive_read(5'd7, 1'b0); #1;
        chk("fl_after_stall", stall, 1);
        chk("fl_after_tag", issue_tag, 1);
        tick();
        drive_read(5'd7, 1'b0); #1;
        chk("fl_release", stall, 0);
        chk("fl_release_fire", issue_fire, 1);
        tick();

        // Reset in the middle of a load wait
        drive_write(5'd9, 3'd0, 1'b1); #1;
        chk("rl_tag", issue_tag, 2);
        tick();
        drive_read(5'd9, 1'b0); #1;
        chk("rl_stall_mem", stall_mem, 1);
        tick();
        drive_read(5'd9, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_read(5'd9, 1'b0); #1;
        chk("rl_post_stall", stall, 0);
        chk("rl_post_mem", stall_mem, 0);
        chk("rl_post_fire", issue_fire, 1);
        chk("rl_post_tag", issue_tag, 0);
        tick();

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
